subtractor_arbiter: RTL and testbench

SUBTRACTOR_ARBITER -- requirements
Module: subtractor_arbiter

---
 rtl/kpn_pkg.sv | 10 +
 rtl/subtractor_arbiter_if.sv | 35 +++
 rtl/rr_arbiter_2.sv | 18 +
 rtl/subtractor_arbiter.sv | 104 ++++++++++
 tb/tb_subtractor_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/kpn_pkg.sv
// Shared constants for the subtractor arbiter: default operand width and FSM state encodings.
package kpn_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/subtractor_arbiter_if.sv
// Request/result bundle between the two requesters and the shared subtractor.
interface subtractor_arbiter_if
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  req_1;
    logic                  req_2;
    logic [DATA_WIDTH-1:0] entry_1_a;
    logic [DATA_WIDTH-1:0] entry_1_b;
    logic [DATA_WIDTH-1:0] entry_2_a;
    logic [DATA_WIDTH-1:0] entry_2_b;
    logic                  ack_1;
    logic                  ack_2;
    logic                  valid_1;
    logic                  valid_2;
    logic [DATA_WIDTH-1:0] output_1;
    logic [DATA_WIDTH-1:0] output_2;
    logic                  borrow_1;
    logic                  borrow_2;
    logic                  ready_1;
    logic                  ready_2;
    logic                  busy;

    modport master (
        output req_1, req_2, entry_1_a, entry_1_b, entry_2_a, entry_2_b, ready_1, ready_2,
        input  ack_1, ack_2, valid_1, valid_2, output_1, output_2, borrow_1, borrow_2, busy
    );

    modport slave (
        input  req_1, req_2, entry_1_a, entry_1_b, entry_2_a, entry_2_b, ready_1, ready_2,
        output ack_1, ack_2, valid_1, valid_2, output_1, output_2, borrow_1, borrow_2, busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick; ptr low favours requester 1 on a tie, high favours requester 2.
module rr_arbiter_2 (
    input  logic       req_1,
    input  logic       req_2,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_1 && (!req_2 || !ptr)) begin
            grant = 2'b01;
        end else if (req_2) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/subtractor_arbiter.sv
// One registered subtractor shared by two requesters under round-robin arbitration.
//   state   | meaning
//   IDLE    | waiting for a request; grant latches operands and pulses ack
//   EXEC    | subtract latched operands, raise valid for the winner
//   HOLD    | result held until the winner's ready is sampled high
module subtractor_arbiter
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic clk,
    input logic reset,
    subtractor_arbiter_if.slave bus
);

    logic [1:0]            state;
    logic                  ptr;
    logic                  winner;
    logic [1:0]            grant;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH:0]   diff_full;
    logic                  ack_1, ack_2;
    logic                  valid_1, valid_2;
    logic [DATA_WIDTH-1:0] out_1, out_2;
    logic                  borrow_1, borrow_2;
    logic                  winner_ready;

    rr_arbiter_2 u_rr (
        .req_1 (bus.req_1),
        .req_2 (bus.req_2),
        .ptr   (ptr),
        .grant (grant)
    );

    // Extra MSB of the widened difference is the unsigned borrow.
    assign diff_full    = {1'b0, op_a} - {1'b0, op_b};
    assign winner_ready = winner ? bus.ready_2 : bus.ready_1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= 1'b0;
            winner   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            ack_1    <= 1'b0;
            ack_2    <= 1'b0;
            valid_1  <= 1'b0;
            valid_2  <= 1'b0;
            out_1    <= '0;
            out_2    <= '0;
            borrow_1 <= 1'b0;
            borrow_2 <= 1'b0;
        end else begin
            ack_1 <= 1'b0;
            ack_2 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        op_a   <= grant[1] ? bus.entry_2_a : bus.entry_1_a;
                        op_b   <= grant[1] ? bus.entry_2_b : bus.entry_1_b;
                        winner <= grant[1];
                        ack_1  <= grant[0];
                        ack_2  <= grant[1];
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (winner) begin
                        out_2    <= diff_full[DATA_WIDTH-1:0];
                        borrow_2 <= diff_full[DATA_WIDTH];
                        valid_2  <= 1'b1;
                    end else begin
                        out_1    <= diff_full[DATA_WIDTH-1:0];
                        borrow_1 <= diff_full[DATA_WIDTH];
                        valid_1  <= 1'b1;
                    end
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (winner_ready) begin
                        valid_1 <= 1'b0;
                        valid_2 <= 1'b0;
                        ptr     <= ~winner;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack_1    = ack_1;
    assign bus.ack_2    = ack_2;
    assign bus.valid_1  = valid_1;
    assign bus.valid_2  = valid_2;
    assign bus.output_1 = out_1;
    assign bus.output_2 = out_2;
    assign bus.borrow_1 = borrow_1;
    assign bus.borrow_2 = borrow_2;
    assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_subtractor_arbiter.sv
// Directed bench for subtractor_arbiter: single requests, wrap-around, round-robin, backpressure, reset.
module tb_subtractor_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    subtractor_arbiter_if #(.DATA_WIDTH(16)) bus ();

    subtractor_arbiter #(.DATA_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},    {30'd0, bus.ack_1, bus.ack_2}, 32'd0);
        chk({tag, "_valid"},  {30'd0, bus.valid_1, bus.valid_2}, 32'd0);
        chk({tag, "_out1"},   {16'd0, bus.output_1}, 32'd0);
        chk({tag, "_out2"},   {16'd0, bus.output_2}, 32'd0);
        chk({tag, "_borrow"}, {30'd0, bus.borrow_1, bus.borrow_2}, 32'd0);
        chk({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
    endtask

    logic [15:0] held_out;

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.req_1     = 1'b0;
        bus.req_2     = 1'b0;
        bus.ready_1   = 1'b0;
        bus.ready_2   = 1'b0;
        bus.entry_1_a = 16'h0000;
        bus.entry_1_b = 16'h0000;
        bus.entry_2_a = 16'h0000;
        bus.entry_2_b = 16'h0000;

        #1;
        chk_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // single request from requester 1
        bus.req_1     = 1'b1;
        bus.entry_1_a = 16'h0010;
        bus.entry_1_b = 16'h0003;
        tick();
        chk("s1_ack1",  bus.ack_1, 1);
        chk("s1_ack2",  bus.ack_2, 0);
        chk("s1_val1_early", bus.valid_1, 0);
        chk("s1_busy",  bus.busy, 1);
        bus.req_1 = 1'b0;
        tick();
        chk("s1_ack1_pulse", bus.ack_1, 0);
        chk("s1_val1",  bus.valid_1, 1);
        chk("s1_val2",  bus.valid_2, 0);
        chk("s1_out1",  bus.output_1, 16'h000D);
        chk("s1_brw1",  bus.borrow_1, 0);
        bus.ready_1 = 1'b1;
        tick();
        chk("s1_val1_clr", bus.valid_1, 0);
        chk("s1_out1_keep", bus.output_1, 16'h000D);
        chk("s1_idle",  bus.busy, 0);
        bus.ready_1 = 1'b0;
        tick();
        chk("idle_no_req_busy", bus.busy, 0);
        chk("idle_no_req_ack", {bus.ack_1, bus.ack_2}, 0);

        // wrap-around on requester 2; ready already high before valid
        bus.req_2     = 1'b1;
        bus.ready_2   = 1'b1;
        bus.entry_2_a = 16'h0000;
        bus.entry_2_b = 16'h0001;
        tick();
        chk("s2_ack2", bus.ack_2, 1);
        chk("s2_ack1", bus.ack_1, 0);
        bus.req_2 = 1'b0;
        tick();
        chk("s2_val2", bus.valid_2, 1);
        chk("s2_out2", bus.output_2, 16'hFFFF);
        chk("s2_brw2", bus.borrow_2, 1);
        tick();
        chk("s2_val2_clr", bus.valid_2, 0);
        chk("s2_out2_keep", bus.output_2, 16'hFFFF);
        bus.ready_2 = 1'b0;

        // round-robin with both requesting; pointer favours 1 after serving 2
        bus.entry_1_a = 16'h0005;
        bus.entry_1_b = 16'h0002;
        bus.entry_2_a = 16'h0002;
        bus.entry_2_b = 16'h0005;
        bus.req_1     = 1'b1;
        bus.req_2     = 1'b1;
        bus.ready_1   = 1'b1;
        bus.ready_2   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rr_ack1_%0d", k), bus.ack_1, (k % 6) == 0);
            chk($sformatf("rr_ack2_%0d", k), bus.ack_2, (k % 6) == 3);
            chk($sformatf("rr_val1_%0d", k), bus.valid_1, (k % 6) == 1);
            chk($sformatf("rr_val2_%0d", k), bus.valid_2, (k % 6) == 4);
            if ((k % 6) == 1) chk($sformatf("rr_out1_%0d", k), {bus.borrow_1, bus.output_1}, 17'h0_0003);
            if ((k % 6) == 4) chk($sformatf("rr_out2_%0d", k), {bus.borrow_2, bus.output_2}, 17'h1_FFFD);
        end
        bus.req_1   = 1'b0;
        bus.req_2   = 1'b0;
        bus.ready_1 = 1'b0;
        bus.ready_2 = 1'b0;

        // backpressure: requester 2 holds off, requester 1 waits
        bus.entry_2_a = 16'h1234;
        bus.entry_2_b = 16'h0234;
        bus.req_2     = 1'b1;
        tick();
        chk("bp_ack2", bus.ack_2, 1);
        bus.req_2     = 1'b0;
        bus.entry_1_a = 16'h0010;
        bus.entry_1_b = 16'h0003;
        bus.req_1     = 1'b1;
        tick();
        chk("bp_val2", bus.valid_2, 1);
        chk("bp_out2", bus.output_2, 16'h1000);
        held_out = 16'h1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold_val2_%0d", i), bus.valid_2, 1);
            chk($sformatf("bp_hold_out2_%0d", i), bus.output_2, held_out);
            chk($sformatf("bp_hold_ack1_%0d", i), bus.ack_1, 0);
        end
        bus.ready_2 = 1'b1;
        tick();
        chk("bp_rel_val2", bus.valid_2, 0);
        chk("bp_rel_ack1", bus.ack_1, 0);
        bus.ready_2 = 1'b0;
        tick();
        chk("bp_late_ack1", bus.ack_1, 1);
        bus.req_1 = 1'b0;
        tick();
        chk("bp_val1", bus.valid_1, 1);
        chk("bp_out1", bus.output_1, 16'h000D);
        bus.ready_1 = 1'b1;
        tick();
        chk("bp_val1_clr", bus.valid_1, 0);
        bus.ready_1 = 1'b0;

        // pointer now favours 2; reset in EXEC must clear it back to 1
        bus.req_1 = 1'b1;
        bus.req_2 = 1'b1;
        tick();
        chk("rst_pre_ack2", bus.ack_2, 1);
        chk("rst_pre_ack1", bus.ack_1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_async");
        bus.req_1 = 1'b0;
        bus.req_2 = 1'b0;
        bus.ready_1 = 1'b1;
        bus.ready_2 = 1'b1;
        tick();
        chk_all_zero("rst_held");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_after_val_%0d", i), {bus.valid_1, bus.valid_2}, 0);
            chk($sformatf("rst_after_ack_%0d", i), {bus.ack_1, bus.ack_2}, 0);
        end
        bus.req_1 = 1'b1;
        bus.req_2 = 1'b1;
        tick();
        chk("rst_post_ack1", bus.ack_1, 1);
        chk("rst_post_ack2", bus.ack_2, 0);
        bus.req_1 = 1'b0;
        bus.req_2 = 1'b0;
        tick();
        chk("rst_post_val1", bus.valid_1, 1);
        chk("rst_post_out1", bus.output_1, 16'h000D);
        tick();
        chk("rst_post_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
